// File: rtl/c7_array_multiplier.sv
// c7_array_multiplier: unsigned 4x4 array multiplier in the tiny-tile user wrapper.
//
// The operands are registered and fed to a structural array of AND-gate
// partial products and half/full adders. The first row passes through, and
// each later row is added by a ripple row. The 8-bit product is registered
// onto uo_out.
//
// Ports:
//   clk      single clock, all state on the rising edge
//   rst      asynchronous, active-high reset
//   ena      design enable; 0 holds every register
//   ui_in    [3:0] = A, [7:4] = B (unsigned)
//   uo_out   registered product A*B
//   uio_in   unused
//   uio_out  [0] = product valid, [7:1] = 0
//   uio_oe   constant 8'b0000_0001
//
// Build option ARRAY_MUL_PIPE_EN adds a register stage after the row-2 adders.
// The products stay the same, and the latency grows from 2 to 3 cycles.
module c7_array_multiplier (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

`ifdef ARRAY_MUL_PIPE_EN
    localparam int unsigned Stages = 3;
`else
    localparam int unsigned Stages = 2;
`endif

    // One ripple row: bit 0 is a half adder, bits 1..3 are full adders, [4] is carry out.
    function automatic logic [4:0] add_row(input logic [3:0] x, input logic [3:0] y);
        logic [4:0] s;
        logic       c;
        c = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s[k] = x[k] ^ y[k] ^ c;
            c    = (x[k] & y[k]) | (c & (x[k] ^ y[k]));
        end
        s[4] = c;
        return s;
    endfunction

    logic                unused_uio;
    logic [3:0]          a_q, a_d, b_q, b_d;
    logic [7:0]          prod_q, prod_d;
    logic [Stages-1:0]   valid_q, valid_d;
    logic [3:0]          pp0, pp1, pp2, pp3;
    logic [4:0]          row1, row2, row3;
    logic [7:0]          p;

    assign unused_uio = ^uio_in;

    always_comb begin
        pp0  = a_q & {4{b_q[0]}};
        pp1  = a_q & {4{b_q[1]}};
        pp2  = a_q & {4{b_q[2]}};
        pp3  = a_q & {4{b_q[3]}};
        // Each row's low sum bit is a final product bit; the upper bits shift down.
        row1 = add_row({1'b0, pp0[3:1]}, pp1);
        row2 = add_row(row1[4:1], pp2);
    end

`ifdef ARRAY_MUL_PIPE_EN
    logic [2:0] lo_q, lo_d;
    logic [3:0] acc_q, acc_d, pp3_q, pp3_d;

    always_comb begin
        lo_d  = ena ? {row2[0], row1[0], pp0[0]} : lo_q;
        acc_d = ena ? row2[4:1] : acc_q;
        pp3_d = ena ? pp3 : pp3_q;
        row3  = add_row(acc_q, pp3_q);
        p     = {row3, lo_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_q  <= '0;
            acc_q <= '0;
            pp3_q <= '0;
        end else begin
            lo_q  <= lo_d;
            acc_q <= acc_d;
            pp3_q <= pp3_d;
        end
    end
`else
    always_comb begin
        row3 = add_row(row2[4:1], pp3);
        p    = {row3, row2[0], row1[0], pp0[0]};
    end
`endif

    always_comb begin
        a_d     = ena ? ui_in[3:0] : a_q;
        b_d     = ena ? ui_in[7:4] : b_q;
        prod_d  = ena ? p : prod_q;
        // A 1 enters on every enabled edge; the oldest bit marks a full pipeline.
        valid_d = ena ? {valid_q[Stages-2:0], 1'b1} : valid_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            valid_q <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            valid_q <= valid_d;
        end
    end

    assign uo_out  = prod_q;
    assign uio_out = {7'b0, valid_q[Stages-1]};
    assign uio_oe  = 8'b0000_0001;

endmodule

// File: tb/tb_c7_array_multiplier.sv
// Self-checking bench for c7_array_multiplier.
// The reference model is a queue of the operand pairs accepted on enabled edges.
// After an enabled edge, the expected output is A*B of the pair accepted LAT edges earlier.
module tb_c7_array_multiplier;

`ifdef ARRAY_MUL_PIPE_EN
    localparam int Lat = 3;
`else
    localparam int Lat = 2;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int         total = 0;
    int         bad = 0;
    logic [7:0] ops[$];

    c7_array_multiplier dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare the DUT with the model's prediction for the current queue.
    task automatic check_model(input string tag);
        logic [7:0] op;
        logic [7:0] exp_p;
        logic       exp_v;
        exp_p = 8'h00;
        exp_v = 1'b0;
        if (ops.size() >= Lat) begin
            op    = ops[ops.size() - Lat];
            exp_p = 8'(int'(op[3:0]) * int'(op[7:4]));
            exp_v = 1'b1;
        end
        check({tag, "_prod"}, uo_out, exp_p);
        check({tag, "_uio"}, uio_out, {7'b0, exp_v});
        check({tag, "_oe"}, uio_oe, 8'h01);
    endtask

    // Drive one cycle, let the edge happen, and sample 1 time unit later.
    task automatic cycle(input logic [7:0] v, input logic en, input string tag);
        ui_in  = v;
        ena    = en;
        uio_in = 8'($urandom);
        @(posedge clk);
        #1;
        if (en) ops.push_back(v);
        check_model(tag);
    endtask

    initial begin
        logic [7:0] cases[5];
        rst    = 1'b0;
        ena    = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;

        // Power-on reset, checked before any clock edge.
        #2 rst = 1'b1;
        #2;
        check("por_prod", uo_out, 8'h00);
        check("por_uio", uio_out, 8'h00);
        check("por_oe", uio_oe, 8'h01);
        @(posedge clk);
        #1 rst = 1'b0;
        ops.delete();

        // Basic: 2*3.
        cycle(8'h32, 1'b1, "basic");
        for (int i = 1; i < Lat; i++) cycle(8'h00, 1'b1, "basic");
        check("basic_six", uo_out, 8'h06);

        // Corners.
        cases = '{8'h00, 8'h0F, 8'hF0, 8'hFF, 8'h11};
        for (int i = 0; i < 5; i++) cycle(cases[i], 1'b1, "corner");
        for (int i = 0; i < Lat; i++) cycle(8'h00, 1'b1, "corner");

        // Streaming without bubbles.
        cycle(8'h45, 1'b1, "stream");
        cycle(8'h9C, 1'b1, "stream");
        cycle(8'h7B, 1'b1, "stream");
        for (int i = 0; i < Lat; i++) cycle(8'h00, 1'b1, "stream");

        // Enable hold while inputs toggle; then resume and drain 10*11.
        cycle(8'hAB, 1'b1, "hold");
        for (int i = 0; i < 5; i++) cycle(8'($urandom), 1'b0, "hold");
        for (int i = 1; i < Lat; i++) cycle(8'h00, 1'b1, "resume");
        check("resume_6e", uo_out, 8'h6E);

        // Asynchronous reset mid-stream with ui_in = 0xFF.
        cycle(8'hFF, 1'b1, "pre_rst");
        cycle(8'hFF, 1'b1, "pre_rst");
        #2 rst = 1'b1;
        #1;
        check("arst_prod", uo_out, 8'h00);
        check("arst_uio", uio_out, 8'h00);
        check("arst_oe", uio_oe, 8'h01);
        @(posedge clk);
        #1 rst = 1'b0;
        ops.delete();
        check_model("post_rst");

        // Exhaustive: all 256 operand pairs, back-to-back.
        for (int i = 0; i < 256; i++) cycle(8'(i), 1'b1, "exh");
        for (int i = 0; i < Lat; i++) cycle(8'h00, 1'b1, "exh");

        // Random data with random enable gaps.
        for (int i = 0; i < 200; i++) cycle(8'($urandom), ($urandom_range(3) != 0), "rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
